// File: rtl/mpu_load_unit_pkg.sv
// Shared constants and types for the MPU matrix load path.
// Sizes are carried one bit wider than indices so that M and N themselves are representable.
package mpu_load_unit_pkg;

    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_BITS = 2;
    localparam int MEM_ADDR_BITS   = 16;

    typedef logic [31:0] float_sp;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        WRITE,
        DONE
    } load_state_t;

    typedef struct packed {
        logic [MATRIX_REG_BITS:0] reg_addr;
        logic [MBITS:0]           m;
        logic [NBITS:0]           n;
        logic [MEM_ADDR_BITS-1:0] base;
    } load_cmd_t;

    function automatic logic dims_invalid(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return (m == '0) || (n == '0) || (int'(m) > M) || (int'(n) > N);
    endfunction

endpackage

// File: rtl/mpu_load_index_counter.sv
// Row-major element walker: i/j position plus linear offset, with last-element flag.
// Single cycle per advance; holds position while advance is low.
module mpu_load_index_counter
    import mpu_load_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     advance,
    input  logic [MBITS:0]           m_size,
    input  logic [NBITS:0]           n_size,
    output logic [MBITS:0]           i,
    output logic [NBITS:0]           j,
    output logic [MEM_ADDR_BITS-1:0] lin,
    output logic                     last
);

    logic last_col;

    assign last_col = (j == n_size - (NBITS+1)'(1));
    assign last     = last_col && (i == m_size - (MBITS+1)'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i   <= '0;
            j   <= '0;
            lin <= '0;
        end else if (advance) begin
            lin <= lin + MEM_ADDR_BITS'(1);
            if (last_col) begin
                j <= '0;
                i <= i + (MBITS+1)'(1);
            end else begin
                j <= j + (NBITS+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mpu_load_unit.sv
// Matrix loader: fetches m*n elements row-major from memory into a register-file load port.
// Two cycles per element when unstalled; mem_rd_ack_in and load_ready_in each stall their own phase.
module mpu_load_unit
    import mpu_load_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_req_in,
    output logic                       ld_ready_out,
    input  logic [MATRIX_REG_BITS:0]   ld_reg_addr_in,
    input  logic [MBITS:0]             ld_m_in,
    input  logic [NBITS:0]             ld_n_in,
    input  logic [MEM_ADDR_BITS-1:0]   ld_mem_base_in,
    output logic                       ld_done_out,
    output logic                       ld_err_out,
    output logic                       mem_rd_req_out,
    output logic [MEM_ADDR_BITS-1:0]   mem_rd_addr_out,
    input  logic                       mem_rd_ack_in,
    input  float_sp                    mem_rd_data_in,
    output logic                       reg_load_req_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out,
    output float_sp                    reg_load_element_out,
    input  logic                       load_ready_in
);

    load_state_t              state_q, state_d;
    load_cmd_t                cmd_q;
    float_sp                  elem_q;
    logic [MBITS:0]           i;
    logic [NBITS:0]           j;
    logic [MEM_ADDR_BITS-1:0] lin;
    logic                     last;
    logic                     accept;
    logic                     advance;

    assign accept  = (state_q == IDLE) && ld_req_in;
    assign advance = (state_q == WRITE) && load_ready_in && !last;

    mpu_load_index_counter u_index (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance (advance),
        .m_size  (cmd_q.m),
        .n_size  (cmd_q.n),
        .i       (i),
        .j       (j),
        .lin     (lin),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q  <= '0;
            elem_q <= '0;
        end else begin
            if (accept) begin
                cmd_q.reg_addr <= ld_reg_addr_in;
                cmd_q.m        <= ld_m_in;
                cmd_q.n        <= ld_n_in;
                cmd_q.base     <= ld_mem_base_in;
            end
            if ((state_q == FETCH) && mem_rd_ack_in) begin
                elem_q <= mem_rd_data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (ld_req_in) state_d = CHECK;
            CHECK: state_d = dims_invalid(cmd_q.m, cmd_q.n) ? IDLE : FETCH;
            FETCH: if (mem_rd_ack_in) state_d = WRITE;
            WRITE: if (load_ready_in) state_d = last ? DONE : FETCH;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command fields stay visible from CHECK through DONE so the register file sees a constant address.
    always_comb begin
        ld_ready_out         = (state_q == IDLE);
        ld_done_out          = (state_q == DONE);
        ld_err_out           = (state_q == CHECK) && dims_invalid(cmd_q.m, cmd_q.n);
        mem_rd_req_out       = (state_q == FETCH);
        mem_rd_addr_out      = '0;
        reg_load_req_out     = (state_q == WRITE);
        reg_load_addr_out    = '0;
        reg_i_load_loc_out   = '0;
        reg_j_load_loc_out   = '0;
        reg_m_load_size_out  = '0;
        reg_n_load_size_out  = '0;
        reg_load_element_out = '0;
        if (state_q != IDLE) begin
            reg_load_addr_out   = cmd_q.reg_addr;
            reg_m_load_size_out = cmd_q.m;
            reg_n_load_size_out = cmd_q.n;
            reg_i_load_loc_out  = i;
            reg_j_load_loc_out  = j;
        end
        if (state_q == FETCH) begin
            mem_rd_addr_out = cmd_q.base + lin;
        end
        if (state_q == WRITE) begin
            reg_load_element_out = elem_q;
        end
    end

endmodule

// File: tb/tb_mpu_load_unit.sv
// Directed bench for mpu_load_unit: memory returns its own address as data, register file is a recorder.
// Cycle c of a command is the one sampled after c edges, counting the accept edge as edge 1.
module tb_mpu_load_unit;
    import mpu_load_unit_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     ld_req_in = 1'b0;
    logic                     ld_ready_out;
    logic [MATRIX_REG_BITS:0] ld_reg_addr_in = '0;
    logic [MBITS:0]           ld_m_in = '0;
    logic [NBITS:0]           ld_n_in = '0;
    logic [MEM_ADDR_BITS-1:0] ld_mem_base_in = '0;
    logic                     ld_done_out;
    logic                     ld_err_out;
    logic                     mem_rd_req_out;
    logic [MEM_ADDR_BITS-1:0] mem_rd_addr_out;
    logic                     mem_rd_ack_in = 1'b0;
    logic [31:0]              mem_rd_data_in = '0;
    logic                     reg_load_req_out;
    logic [MATRIX_REG_BITS:0] reg_load_addr_out;
    logic [MBITS:0]           reg_i_load_loc_out;
    logic [NBITS:0]           reg_j_load_loc_out;
    logic [MBITS:0]           reg_m_load_size_out;
    logic [NBITS:0]           reg_n_load_size_out;
    logic [31:0]              reg_load_element_out;
    logic                     load_ready_in = 1'b0;

    mpu_load_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .ld_req_in            (ld_req_in),
        .ld_ready_out         (ld_ready_out),
        .ld_reg_addr_in       (ld_reg_addr_in),
        .ld_m_in              (ld_m_in),
        .ld_n_in              (ld_n_in),
        .ld_mem_base_in       (ld_mem_base_in),
        .ld_done_out          (ld_done_out),
        .ld_err_out           (ld_err_out),
        .mem_rd_req_out       (mem_rd_req_out),
        .mem_rd_addr_out      (mem_rd_addr_out),
        .mem_rd_ack_in        (mem_rd_ack_in),
        .mem_rd_data_in       (mem_rd_data_in),
        .reg_load_req_out     (reg_load_req_out),
        .reg_load_addr_out    (reg_load_addr_out),
        .reg_i_load_loc_out   (reg_i_load_loc_out),
        .reg_j_load_loc_out   (reg_j_load_loc_out),
        .reg_m_load_size_out  (reg_m_load_size_out),
        .reg_n_load_size_out  (reg_n_load_size_out),
        .reg_load_element_out (reg_load_element_out),
        .load_ready_in        (load_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [2:0]  i;
        logic [2:0]  j;
        logic [2:0]  m;
        logic [2:0]  n;
        logic [31:0] elem;
        int          hold;
    } wr_t;

    wr_t wr_q[$];
    int  checks = 0;
    int  errors = 0;

    // Responder-owned observation state
    int          cyc = 0, done_cnt = 0, err_cnt = 0, done_at = 0, err_at = 0;
    int          mem_cyc = 0, reg_cyc = 0, stab_err = 0, excl_err = 0;
    int          wait_cnt, hold, stall_run;
    logic        p_mem, p_ack, p_reg, p_wr;
    logic [15:0] p_addr;
    logic [46:0] cur_f, p_f;

    // Main-process-owned knobs and snapshots
    int ack_delay = 0, stall_i = -1, stall_j = -1, stall_len = 0;
    int s_done, s_err, s_wr, s_mem, s_reg, s_c0;

    initial begin : responder
        wait_cnt = 0; hold = 0; stall_run = 0;
        p_mem = 1'b0; p_ack = 1'b0; p_reg = 1'b0; p_wr = 1'b0;
        p_addr = '0; p_f = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ld_done_out) begin done_cnt++; done_at = cyc; end
            if (ld_err_out) begin err_cnt++; err_at = cyc; end
            if (mem_rd_req_out && reg_load_req_out) excl_err++;
            if (mem_rd_req_out) begin
                mem_cyc++;
                if (p_mem && !p_ack && mem_rd_addr_out !== p_addr) stab_err++;
                p_addr = mem_rd_addr_out;
                if (wait_cnt >= ack_delay) begin
                    mem_rd_ack_in  = 1'b1;
                    mem_rd_data_in = {16'h0000, mem_rd_addr_out};
                    wait_cnt       = 0;
                end else begin
                    mem_rd_ack_in = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_rd_ack_in = 1'b0;
                wait_cnt      = 0;
            end
            p_mem = mem_rd_req_out;
            p_ack = mem_rd_ack_in;
            cur_f = {reg_load_addr_out, reg_i_load_loc_out, reg_j_load_loc_out,
                     reg_m_load_size_out, reg_n_load_size_out, reg_load_element_out};
            if (reg_load_req_out) begin
                reg_cyc++;
                hold++;
                if (p_reg && !p_wr && cur_f !== p_f) stab_err++;
                p_f = cur_f;
                if (int'(reg_i_load_loc_out) == stall_i && int'(reg_j_load_loc_out) == stall_j
                    && stall_run < stall_len) begin
                    load_ready_in = 1'b0;
                    stall_run++;
                end else begin
                    load_ready_in = 1'b1;
                end
                if (load_ready_in) begin
                    wr_q.push_back('{reg_load_addr_out, reg_i_load_loc_out, reg_j_load_loc_out,
                                     reg_m_load_size_out, reg_n_load_size_out, reg_load_element_out, hold});
                    hold      = 0;
                    stall_run = 0;
                end
            end else begin
                load_ready_in = 1'b1;
                hold          = 0;
            end
            p_reg = reg_load_req_out;
            p_wr  = reg_load_req_out && load_ready_in;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snapshot();
        s_done = done_cnt; s_err = err_cnt; s_wr = wr_q.size(); s_mem = mem_cyc; s_reg = reg_cyc;
    endtask

    task automatic run_cmd(input logic [2:0] a, input logic [2:0] m, input logic [2:0] n,
                           input logic [15:0] base, input string name);
        snapshot();
        checks++;
        if (ld_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_cmd got %b want 1", name, ld_ready_out);
        end
        ld_reg_addr_in = a; ld_m_in = m; ld_n_in = n; ld_mem_base_in = base;
        ld_req_in = 1'b1;
        s_c0 = cyc;
        tick();
        ld_req_in = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt != s_done || err_cnt != s_err) break;
            tick();
        end
        checks++;
        if (done_cnt == s_done && err_cnt == s_err) begin
            errors++;
            $display("FAIL %s timeout got no done/err pulse want one within 300 cycles", name);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        ld_req_in = 1'b1;
        tick();
        checks++;
        if (ld_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", ld_ready_out);
        end
        checks++;
        if ({ld_done_out, ld_err_out, mem_rd_req_out, mem_rd_addr_out, reg_load_req_out, reg_load_addr_out,
             reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out, reg_n_load_size_out,
             reg_load_element_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero (mem_req=%b reg_req=%b done=%b err=%b) want all 0",
                     mem_rd_req_out, reg_load_req_out, ld_done_out, ld_err_out);
        end
        tick();
        tick();
        ld_req_in = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({ld_ready_out, mem_rd_req_out, reg_load_req_out} !== 3'b100 || mem_cyc != 0) begin
            errors++;
            $display("FAIL reset_ignores_req got ready=%b mem_req=%b reg_req=%b mem_cyc=%0d want 1/0/0/0",
                     ld_ready_out, mem_rd_req_out, reg_load_req_out, mem_cyc);
        end
    endtask

    task automatic test_basic();
        run_cmd(3'd1, 3'd2, 3'd2, 16'h0010, "basic");
        checks++;
        if (wr_q.size() - s_wr != 4) begin
            errors++;
            $display("FAIL basic_count got %0d want 4", wr_q.size() - s_wr);
        end
        for (int k = 0; k < 4 && s_wr + k < wr_q.size(); k++) begin
            wr_t w;
            w = wr_q[s_wr + k];
            checks++;
            if ({w.addr, w.i, w.j, w.m, w.n, w.elem} !== {3'd1, 3'(k / 2), 3'(k % 2), 3'd2, 3'd2, 32'h10 + 32'(k)}) begin
                errors++;
                $display("FAIL basic_wr%0d got a=%0d i=%0d j=%0d m=%0d n=%0d d=%h want a=1 i=%0d j=%0d m=2 n=2 d=%h",
                         k, w.addr, w.i, w.j, w.m, w.n, w.elem, k / 2, k % 2, 32'h10 + 32'(k));
            end
        end
        checks++;
        if (done_at - s_c0 != 10 || done_cnt - s_done != 1 || err_cnt != s_err) begin
            errors++;
            $display("FAIL basic_done got cycle=%0d pulses=%0d errs=%0d want 10/1/0",
                     done_at - s_c0, done_cnt - s_done, err_cnt - s_err);
        end
    endtask

    task automatic test_stall();
        stall_i = 0; stall_j = 1; stall_len = 3;
        run_cmd(3'd2, 3'd2, 3'd2, 16'h0020, "stall");
        stall_len = 0;
        checks++;
        if (wr_q.size() - s_wr != 4) begin
            errors++;
            $display("FAIL stall_count got %0d want 4", wr_q.size() - s_wr);
        end else begin
            checks++;
            if (wr_q[s_wr + 1].hold != 4 || wr_q[s_wr + 1].elem !== 32'h21 || wr_q[s_wr + 3].elem !== 32'h23) begin
                errors++;
                $display("FAIL stall_elem got hold=%0d d1=%h d3=%h want 4/00000021/00000023",
                         wr_q[s_wr + 1].hold, wr_q[s_wr + 1].elem, wr_q[s_wr + 3].elem);
            end
        end
        checks++;
        if (stab_err != 0 || excl_err != 0 || done_at - s_c0 != 13) begin
            errors++;
            $display("FAIL stall_hold got unstable=%0d overlap=%0d done=%0d want 0/0/13",
                     stab_err, excl_err, done_at - s_c0);
        end
    endtask

    task automatic test_ack_delay();
        ack_delay = 5;
        run_cmd(3'd3, 3'd1, 3'd2, 16'h0040, "ackdly");
        ack_delay = 0;
        checks++;
        if (done_at - s_c0 != 16 || mem_cyc - s_mem != 12 || stab_err != 0) begin
            errors++;
            $display("FAIL ackdly_timing got done=%0d mem_cycles=%0d unstable=%0d want 16/12/0",
                     done_at - s_c0, mem_cyc - s_mem, stab_err);
        end
        checks++;
        if (wr_q.size() - s_wr != 2 || wr_q[wr_q.size() - 1].elem !== 32'h41 || wr_q[wr_q.size() - 1].j !== 3'd1) begin
            errors++;
            $display("FAIL ackdly_data got count=%0d last_d=%h last_j=%0d want 2/00000041/1",
                     wr_q.size() - s_wr, wr_q[wr_q.size() - 1].elem, wr_q[wr_q.size() - 1].j);
        end
    endtask

    task automatic test_errors();
        logic [2:0] ms[3] = '{3'd0, 3'd5, 3'd1};
        logic [2:0] ns[3] = '{3'd2, 3'd1, 3'd5};
        for (int t = 0; t < 3; t++) begin
            run_cmd(3'd4, ms[t], ns[t], 16'h0100, "err");
            checks++;
            if (err_cnt - s_err != 1 || done_cnt != s_done || err_at - s_c0 < 1 || err_at - s_c0 > 2) begin
                errors++;
                $display("FAIL err%0d_pulse got errs=%0d dones=%0d cycle=%0d want 1/0/1..2",
                         t, err_cnt - s_err, done_cnt - s_done, err_at - s_c0);
            end
            checks++;
            if (mem_cyc != s_mem || reg_cyc != s_reg || ld_ready_out !== 1'b1) begin
                errors++;
                $display("FAIL err%0d_quiet got mem=%0d reg=%0d ready=%b want 0/0/1",
                         t, mem_cyc - s_mem, reg_cyc - s_reg, ld_ready_out);
            end
        end
    endtask

    task automatic test_shapes();
        logic [2:0]  ms[3] = '{3'd1, 3'd4, 3'd4};
        logic [2:0]  ns[3] = '{3'd3, 3'd1, 3'd4};
        logic [15:0] bs[3] = '{16'hFFFE, 16'h0100, 16'h0200};
        for (int t = 0; t < 3; t++) begin
            int cnt;
            run_cmd(3'd5, ms[t], ns[t], bs[t], "shape");
            cnt = int'(ms[t]) * int'(ns[t]);
            checks++;
            if (wr_q.size() - s_wr != cnt || done_at - s_c0 != 2 + 2 * cnt) begin
                errors++;
                $display("FAIL shape%0d_count got writes=%0d done=%0d want %0d/%0d",
                         t, wr_q.size() - s_wr, done_at - s_c0, cnt, 2 + 2 * cnt);
            end
            for (int k = 0; k < cnt && s_wr + k < wr_q.size(); k++) begin
                wr_t         w;
                logic [15:0] ea;
                w  = wr_q[s_wr + k];
                ea = bs[t] + 16'(k);
                checks++;
                if ({w.i, w.j, w.elem} !== {3'(k / int'(ns[t])), 3'(k % int'(ns[t])), 16'h0000, ea}) begin
                    errors++;
                    $display("FAIL shape%0d_wr%0d got i=%0d j=%0d d=%h want i=%0d j=%0d d=%h",
                             t, k, w.i, w.j, w.elem, k / int'(ns[t]), k % int'(ns[t]), ea);
                end
            end
        end
        checks++;
        if (excl_err != 0 || stab_err != 0) begin
            errors++;
            $display("FAIL shapes_protocol got overlap=%0d unstable=%0d want 0/0", excl_err, stab_err);
        end
    endtask

    task automatic test_reset_mid();
        snapshot();
        ld_reg_addr_in = 3'd6; ld_m_in = 3'd2; ld_n_in = 3'd2; ld_mem_base_in = 16'h0050;
        ld_req_in = 1'b1;
        tick();
        ld_req_in = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (wr_q.size() - s_wr >= 2) break;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ld_ready_out, mem_rd_req_out, reg_load_req_out} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_idle got ready=%b mem_req=%b reg_req=%b want 1/0/0",
                     ld_ready_out, mem_rd_req_out, reg_load_req_out);
        end
        repeat (5) tick();
        checks++;
        if (done_cnt != s_done || err_cnt != s_err || mem_cyc - s_mem > 3) begin
            errors++;
            $display("FAIL rstmid_nopulse got dones=%0d errs=%0d mem=%0d want 0/0/<=3",
                     done_cnt - s_done, err_cnt - s_err, mem_cyc - s_mem);
        end
        run_cmd(3'd2, 3'd1, 3'd1, 16'h0077, "after_rst");
        checks++;
        if (wr_q.size() - s_wr != 1 || done_at - s_c0 != 4 ||
            {wr_q[wr_q.size() - 1].i, wr_q[wr_q.size() - 1].j, wr_q[wr_q.size() - 1].elem} !== {3'd0, 3'd0, 32'h77}) begin
            errors++;
            $display("FAIL after_rst got writes=%0d done=%0d last_d=%h want 1/4/00000077",
                     wr_q.size() - s_wr, done_at - s_c0, wr_q[wr_q.size() - 1].elem);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ack_delay();
        test_errors();
        test_shapes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
